// File: rtl/bcd_pkg.sv
// Shared constants for the BCD counter: digit width, largest decimal digit,
// mode encodings, and a per-digit clamp used when loading external values.
package bcd_pkg;

    localparam int          DIGIT_W   = 4;
    localparam logic [3:0]  MAX_DIGIT = 4'd9;

    localparam logic WRAP = 1'b0;
    localparam logic SAT  = 1'b1;

    // Non-decimal nibbles (A..F) are forced to 9 so the count stays valid BCD.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
        return (d > MAX_DIGIT) ? MAX_DIGIT : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the counter. The carry/borrow chain between decades is purely
// combinational, so a full ripple (e.g. 0999 -> 1000) resolves in one cycle.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               inc,
    input  logic               dec,
    input  logic               carry_in,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] digit_next,
    output logic               carry_out,
    output logic               borrow_out
);

    // Step this decade only when the step request reaches it through the chain.
    always_comb begin
        digit_next = digit;
        carry_out  = 1'b0;
        borrow_out = 1'b0;
        if (inc && carry_in) begin
            if (digit == MAX_DIGIT) begin
                digit_next = '0;
                carry_out  = 1'b1;
            end else begin
                digit_next = digit + 4'd1;
            end
        end else if (dec && borrow_in) begin
            if (digit == '0) begin
                digit_next = MAX_DIGIT;
                borrow_out = 1'b1;
            end else begin
                digit_next = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_counter_n.sv
// N-decade up/down BCD counter with edge-detected controls, clamped load,
// wrap/saturate limit handling and registered ovf/unf/zero flags.
// The limit mode is a register that resets to SAT_DEFAULT and then follows
// sat_mode each cycle, so a mode change applies from the following cycle on.
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter bit SAT_DEFAULT = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_a,
    input  logic                      en,
    input  logic                      up,
    input  logic                      down,
    input  logic                      clear,
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] load_val,
    input  logic                      sat_mode,
    output logic [DIGIT_W*DIGITS-1:0] count,
    output logic                      ovf,
    output logic                      unf,
    output logic                      zero
);

    localparam int W = DIGIT_W * DIGITS;

    logic          up_q, down_q, clear_q;
    logic          up_ev, down_ev, clear_ev;
    logic          mode_q;
    logic          step_inc, step_dec;
    logic [DIGITS:0] carry, borrow;
    logic [W-1:0]  step_val;
    logic [W-1:0]  load_clamped;
    logic [W-1:0]  count_next;
    logic          ovf_next, unf_next;

    // Edge-detector history; keeps tracking levels regardless of en.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            up_q    <= up;
            down_q  <= down;
            clear_q <= clear;
        end
    end

    assign up_ev    = up    & ~up_q;
    assign down_ev  = down  & ~down_q;
    assign clear_ev = clear & ~clear_q;

    // Limit-mode register.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            mode_q <= SAT_DEFAULT;
        end else begin
            mode_q <= sat_mode;
        end
    end

    // A step only happens when neither clear nor load claims the cycle, and
    // simultaneous up/down events cancel out entirely.
    assign step_inc = en & up_ev   & ~down_ev & ~clear_ev & ~load;
    assign step_dec = en & down_ev & ~up_ev   & ~clear_ev & ~load;

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .digit      (count[i*DIGIT_W +: DIGIT_W]),
            .inc        (step_inc),
            .dec        (step_dec),
            .carry_in   (carry[i]),
            .borrow_in  (borrow[i]),
            .digit_next (step_val[i*DIGIT_W +: DIGIT_W]),
            .carry_out  (carry[i+1]),
            .borrow_out (borrow[i+1])
        );
        assign load_clamped[i*DIGIT_W +: DIGIT_W] = clamp_digit(load_val[i*DIGIT_W +: DIGIT_W]);
    end

    // Priority select: clear, then load, then a single step.
    // A carry/borrow out of the top decade marks the all-nines / zero limit.
    always_comb begin
        count_next = count;
        ovf_next   = 1'b0;
        unf_next   = 1'b0;
        if (clear_ev) begin
            count_next = '0;
        end else if (load) begin
            count_next = load_clamped;
        end else if (step_inc) begin
            ovf_next = carry[DIGITS];
            if (!(carry[DIGITS] && (mode_q == SAT))) begin
                count_next = step_val;
            end
        end else if (step_dec) begin
            unf_next = borrow[DIGITS];
            if (!(borrow[DIGITS] && (mode_q == SAT))) begin
                count_next = step_val;
            end
        end
    end

    // Count and status flags.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            zero  <= 1'b1;
        end else begin
            count <= count_next;
            ovf   <= ovf_next;
            unf   <= unf_next;
            zero  <= (count_next == '0);
        end
    end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n (DIGITS=4). A decimal-integer model tracks the
// expected count; outputs are compared against it on every falling edge, and
// directed sequences add literal expectations.
module tb_bcd_counter_n;

    localparam int D    = 4;
    localparam int MAXV = 9999;

    logic          clk = 1'b0;
    logic          rst_a = 1'b0;
    logic          en = 1'b1;
    logic          up = 1'b0;
    logic          down = 1'b0;
    logic          clear = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   load_val = 16'h0000;
    logic          sat_mode = 1'b0;
    logic [15:0]   count;
    logic          ovf, unf, zero;

    int checks = 0;
    int errors = 0;

    // Model state: count as a plain integer 0..9999.
    int   m_val = 0;
    logic m_ovf = 1'b0, m_unf = 1'b0, m_mode = 1'b0;
    logic pu = 1'b0, pd = 1'b0, pc = 1'b0;

    always #5 clk = ~clk;

    bcd_counter_n #(.DIGITS(D), .SAT_DEFAULT(1'b0)) dut (
        .clk      (clk),
        .rst_a    (rst_a),
        .en       (en),
        .up       (up),
        .down     (down),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .sat_mode (sat_mode),
        .count    (count),
        .ovf      (ovf),
        .unf      (unf),
        .zero     (zero)
    );

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        r = 16'h0000;
        t = v;
        for (int i = 0; i < D; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int clamp_val(input logic [15:0] lv);
        int s, mul, n;
        s = 0;
        mul = 1;
        for (int i = 0; i < D; i++) begin
            n = int'(lv[i*4 +: 4]);
            if (n > 9) n = 9;
            s = s + n * mul;
            mul = mul * 10;
        end
        return s;
    endfunction

    // Reference model, evaluated from the sampled inputs on each rising edge.
    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            m_val  <= 0;
            m_ovf  <= 1'b0;
            m_unf  <= 1'b0;
            m_mode <= 1'b0;
            pu     <= 1'b0;
            pd     <= 1'b0;
            pc     <= 1'b0;
        end else begin
            automatic bit ue = up && !pu;
            automatic bit de = down && !pd;
            automatic bit ce = clear && !pc;
            automatic int nv = m_val;
            automatic bit no = 1'b0;
            automatic bit nu = 1'b0;
            if (ce) nv = 0;
            else if (load) nv = clamp_val(load_val);
            else if (en && ue && !de) begin
                if (m_val == MAXV) begin
                    no = 1'b1;
                    nv = m_mode ? MAXV : 0;
                end else nv = m_val + 1;
            end else if (en && de && !ue) begin
                if (m_val == 0) begin
                    nu = 1'b1;
                    nv = m_mode ? 0 : MAXV;
                end else nv = m_val - 1;
            end
            m_val  <= nv;
            m_ovf  <= no;
            m_unf  <= nu;
            m_mode <= sat_mode;
            pu     <= up;
            pd     <= down;
            pc     <= clear;
        end
    end

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        check("model_count", count, to_bcd(m_val));
        check("model_ovf", 16'(ovf), 16'(m_ovf));
        check("model_unf", 16'(unf), 16'(m_unf));
        check("model_zero", 16'(zero), 16'(m_val == 0));
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tick(2);
        check("reset_count", count, 16'h0000);
        check("reset_zero", 16'(zero), 16'h0001);
        check("reset_ovf", 16'(ovf), 16'h0000);
        #1 rst_a = 1'b1;
        tick(2);

        // Held up level produces a single increment.
        up = 1'b1;
        tick();
        check("hold_up_first", count, 16'h0001);
        check("hold_up_zero", 16'(zero), 16'h0000);
        tick(9);
        check("hold_up_10", count, 16'h0001);
        up = 1'b0;
        tick();

        // Carry and borrow ripple through several decades.
        load = 1'b1; load_val = 16'h0999;
        tick();
        load = 1'b0;
        check("load_0999", count, 16'h0999);
        up = 1'b1;
        tick();
        check("ripple_up", count, 16'h1000);
        check("ripple_up_ovf", 16'(ovf), 16'h0000);
        up = 1'b0; down = 1'b1;
        tick();
        check("ripple_down", count, 16'h0999);
        down = 1'b0;
        tick();

        // Wrap mode limits.
        load = 1'b1; load_val = 16'h9999;
        tick();
        load = 1'b0; up = 1'b1;
        tick();
        check("wrap_up", count, 16'h0000);
        check("wrap_ovf", 16'(ovf), 16'h0001);
        up = 1'b0;
        tick();
        check("wrap_ovf_once", 16'(ovf), 16'h0000);
        down = 1'b1;
        tick();
        check("wrap_down", count, 16'h9999);
        check("wrap_unf", 16'(unf), 16'h0001);
        down = 1'b0;
        tick();
        check("wrap_unf_once", 16'(unf), 16'h0000);

        // Saturate mode limits.
        sat_mode = 1'b1;
        tick();
        load = 1'b1; load_val = 16'h9999;
        tick();
        load = 1'b0; up = 1'b1;
        tick();
        check("sat_up", count, 16'h9999);
        check("sat_ovf", 16'(ovf), 16'h0001);
        up = 1'b0; load = 1'b1; load_val = 16'h0000;
        tick();
        load = 1'b0; down = 1'b1;
        tick();
        check("sat_down", count, 16'h0000);
        check("sat_unf", 16'(unf), 16'h0001);
        down = 1'b0; sat_mode = 1'b0;
        tick();

        // Priority and load clamp.
        clear = 1'b1; load = 1'b1; load_val = 16'h1234; up = 1'b1;
        tick();
        check("prio_clear", count, 16'h0000);
        clear = 1'b0; up = 1'b0; load_val = 16'h1F2A;
        tick();
        check("load_clamp", count, 16'h1929);
        load = 1'b0;
        tick();

        // Simultaneous up/down, and edge lost while disabled.
        up = 1'b1; down = 1'b1;
        tick();
        check("updown_same", count, 16'h1929);
        check("updown_no_ovf", 16'(ovf | unf), 16'h0000);
        up = 1'b0; down = 1'b0;
        tick();
        en = 1'b0; up = 1'b1;
        tick();
        check("en_low", count, 16'h1929);
        en = 1'b1;
        tick();
        check("edge_lost", count, 16'h1929);
        up = 1'b0;
        tick();

        // Asynchronous reset mid-sequence; input high at release counts once.
        up = 1'b1;
        #1 rst_a = 1'b0;
        #1 check("async_reset", count, 16'h0000);
        tick(2);
        #1 rst_a = 1'b1;
        tick();
        check("release_edge", count, 16'h0001);
        up = 1'b0;
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            tick();
            up    = 1'($urandom_range(0, 1));
            down  = 1'($urandom_range(0, 1));
            clear = ($urandom_range(0, 11) == 0);
            load  = ($urandom_range(0, 9) == 0);
            en    = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 3))
                0: load_val = 16'($urandom);
                1: load_val = 16'h9999;
                2: load_val = 16'h0000;
                default: load_val = {8'h99, 8'($urandom)};
            endcase
            if ($urandom_range(0, 49) == 0) sat_mode = ~sat_mode;
            if (!rst_a) begin
                #1 rst_a = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                #1 rst_a = 1'b0;
            end
        end
        #1 rst_a = 1'b1;
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
